// File: rtl/mano_control_unit_pkg.sv
// rtl/mano_control_unit_pkg.sv - shared encodings for the basic-computer control unit
// Holds bus select codes, register bit positions for LD/INR/CLR, opcode values,
// register-reference bit positions, ALU op codes and the run-state encoding.
package mano_control_unit_pkg;

  // Bus source codes driven on select
  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

  // LD bit positions
  localparam int LD_AR = 0;
  localparam int LD_PC = 1;
  localparam int LD_DR = 2;
  localparam int LD_AC = 3;
  localparam int LD_IR = 4;
  localparam int LD_TR = 5;

  // INR / CLR bit positions (shared map)
  localparam int RG_AR = 0;
  localparam int RG_PC = 1;
  localparam int RG_DR = 2;
  localparam int RG_AC = 3;
  localparam int RG_TR = 4;

  // Opcode field D = IR[14:12]
  localparam logic [2:0] D_AND = 3'd0;
  localparam logic [2:0] D_ADD = 3'd1;
  localparam logic [2:0] D_LDA = 3'd2;
  localparam logic [2:0] D_STA = 3'd3;
  localparam logic [2:0] D_BUN = 3'd4;
  localparam logic [2:0] D_BSA = 3'd5;
  localparam logic [2:0] D_ISZ = 3'd6;
  localparam logic [2:0] D_REG = 3'd7;

  // Register-reference bit positions within IR[11:0]
  localparam int RB_CLA = 11;
  localparam int RB_CMA = 9;
  localparam int RB_INC = 5;
  localparam int RB_SPA = 4;
  localparam int RB_SNA = 3;
  localparam int RB_SZA = 2;
  localparam int RB_HLT = 0;

  // AC input selection
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_CMA  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } run_state_t;

endpackage

// File: rtl/mano_control_unit_if.sv
// rtl/mano_control_unit_if.sv - control/status bundle between control unit and common_bus
// Inputs to the control unit: start, ir_in, ac_zero, ac_sign, dr_zero.
// Outputs from the control unit: select, LD, INR, CLR, read, write, alu_op, halted.
interface mano_control_unit_if;
  logic        start;
  logic [15:0] ir_in;
  logic        ac_zero;
  logic        ac_sign;
  logic        dr_zero;
  logic [2:0]  select;
  logic [5:0]  LD;
  logic [4:0]  INR;
  logic [4:0]  CLR;
  logic        read;
  logic        write;
  logic [2:0]  alu_op;
  logic        halted;

  modport master (
    input  start, ir_in, ac_zero, ac_sign, dr_zero,
    output select, LD, INR, CLR, read, write, alu_op, halted
  );

  modport slave (
    output start, ir_in, ac_zero, ac_sign, dr_zero,
    input  select, LD, INR, CLR, read, write, alu_op, halted
  );
endinterface

// File: rtl/mano_control_unit_sequence_counter.sv
// rtl/mano_control_unit_sequence_counter.sv - timing sequence counter with one-hot T decode
// Ports: clock, reset_n (async active-low), inc, clr (clr wins), t[6:0] one-hot T0..T6.
// Codes above 6 decode to no active T so the top can fall back to IDLE.
module mano_control_unit_sequence_counter #(
  parameter int SC_W = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [6:0] t
);

  logic [SC_W-1:0] sc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sc <= '0;
    end else if (clr) begin
      sc <= '0;
    end else if (inc) begin
      sc <= sc + 1'b1;
    end
  end

  always_comb begin
    t = '0;
    for (int i = 0; i < 7; i++) begin
      t[i] = (sc == SC_W'(i));
    end
  end

endmodule

// File: rtl/mano_control_unit.sv
// rtl/mano_control_unit.sv - fetch/decode/execute control for the 16-bit basic computer
// Ports: clock, reset_n (async active-low), bus (master modport: start, ir_in,
// ac_zero, ac_sign, dr_zero in; select, LD, INR, CLR, read, write, alu_op, halted out).
// Controls are combinational from registered state, so common_bus acts on them
// at the very next rising edge.
module mano_control_unit
  import mano_control_unit_pkg::*;
#(
  parameter int SC_W   = 4,
  parameter int ADDR_W = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mano_control_unit_if.master  bus
);

  run_state_t state, next_state;
  logic [6:0] t;
  logic       sc_inc, sc_clr;
  logic       d_load;
  logic [2:0] d_reg;
  logic       i_reg;

  logic [2:0] sel;
  logic [5:0] ld;
  logic [4:0] inr;
  logic [4:0] clr;
  logic       rd, wr;
  logic [2:0] alu;
  logic       hi_valid;
  int         hi_idx;

  mano_control_unit_sequence_counter #(.SC_W(SC_W)) u_sc (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (sc_inc),
    .clr     (sc_clr),
    .t       (t)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      d_reg <= '0;
      i_reg <= 1'b0;
    end else if (d_load) begin
      d_reg <= bus.ir_in[14:12];
      i_reg <= bus.ir_in[15];
    end
  end

  // Highest set bit of the address field selects the register-reference op
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = 0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (bus.ir_in[i]) begin
        hi_valid = 1'b1;
        hi_idx   = i;
      end
    end
  end

  always_comb begin
    next_state = state;
    sc_inc     = 1'b0;
    sc_clr     = 1'b0;
    d_load     = 1'b0;
    sel        = SEL_NONE;
    ld         = '0;
    inr        = '0;
    clr        = '0;
    rd         = 1'b0;
    wr         = 1'b0;
    alu        = ALU_PASS;

    case (state)
      ST_RUN: begin
        if (t[0]) begin
          sel        = SEL_PC;
          ld[LD_AR]  = 1'b1;
          sc_inc     = 1'b1;
        end else if (t[1]) begin
          sel        = SEL_MEM;
          rd         = 1'b1;
          ld[LD_IR]  = 1'b1;
          inr[RG_PC] = 1'b1;
          sc_inc     = 1'b1;
        end else if (t[2]) begin
          sel        = SEL_IR;
          ld[LD_AR]  = 1'b1;
          d_load     = 1'b1;
          sc_inc     = 1'b1;
        end else if (t[3]) begin
          if (d_reg != D_REG) begin
            // Indirect: replace AR with the pointer read from memory
            if (i_reg) begin
              sel       = SEL_MEM;
              rd        = 1'b1;
              ld[LD_AR] = 1'b1;
            end
            sc_inc = 1'b1;
          end else begin
            sc_clr = 1'b1;
            if (!i_reg && hi_valid) begin
              case (hi_idx)
                RB_CLA: clr[RG_AC] = 1'b1;
                RB_CMA: begin
                  ld[LD_AC] = 1'b1;
                  alu       = ALU_CMA;
                end
                RB_INC: inr[RG_AC] = 1'b1;
                RB_SPA: inr[RG_PC] = !bus.ac_sign;
                RB_SNA: inr[RG_PC] = bus.ac_sign;
                RB_SZA: inr[RG_PC] = bus.ac_zero;
                RB_HLT: next_state = ST_HALTED;
                default: ;
              endcase
            end
          end
        end else if (t[4]) begin
          case (d_reg)
            D_AND, D_ADD, D_LDA, D_ISZ: begin
              sel       = SEL_MEM;
              rd        = 1'b1;
              ld[LD_DR] = 1'b1;
              sc_inc    = 1'b1;
            end
            D_STA: begin
              sel    = SEL_AC;
              wr     = 1'b1;
              sc_clr = 1'b1;
            end
            D_BUN: begin
              sel       = SEL_AR;
              ld[LD_PC] = 1'b1;
              sc_clr    = 1'b1;
            end
            D_BSA: begin
              sel        = SEL_PC;
              wr         = 1'b1;
              inr[RG_AR] = 1'b1;
              sc_inc     = 1'b1;
            end
            default: begin
              next_state = ST_IDLE;
              sc_clr     = 1'b1;
            end
          endcase
        end else if (t[5]) begin
          case (d_reg)
            D_AND: begin
              ld[LD_AC] = 1'b1;
              alu       = ALU_AND;
              sc_clr    = 1'b1;
            end
            D_ADD: begin
              ld[LD_AC] = 1'b1;
              alu       = ALU_ADD;
              sc_clr    = 1'b1;
            end
            D_LDA: begin
              sel       = SEL_DR;
              ld[LD_AC] = 1'b1;
              sc_clr    = 1'b1;
            end
            D_BSA: begin
              sel       = SEL_AR;
              ld[LD_PC] = 1'b1;
              sc_clr    = 1'b1;
            end
            D_ISZ: begin
              inr[RG_DR] = 1'b1;
              sc_inc     = 1'b1;
            end
            default: begin
              next_state = ST_IDLE;
              sc_clr     = 1'b1;
            end
          endcase
        end else if (t[6] && d_reg == D_ISZ) begin
          // DR was incremented at T5; zero here means it wrapped, so skip
          sel        = SEL_DR;
          wr         = 1'b1;
          inr[RG_PC] = bus.dr_zero;
          sc_clr     = 1'b1;
        end else begin
          next_state = ST_IDLE;
          sc_clr     = 1'b1;
        end
      end
      default: begin
        sc_clr = 1'b1;
        if (bus.start) begin
          next_state = ST_RUN;
        end
      end
    endcase
  end

  assign bus.select = sel;
  assign bus.LD     = ld;
  assign bus.INR    = inr;
  assign bus.CLR    = clr;
  assign bus.read   = rd;
  assign bus.write  = wr;
  assign bus.alu_op = alu;
  assign bus.halted = (state == ST_HALTED);

endmodule
